bus_transfer_sequencer: RTL

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

---
 rtl/bus_pkg.sv | 70 +++++++
 rtl/bus_onehot_decoder.sv | 21 ++
 rtl/bus_transfer_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types, register codes and one-hot decode helpers for the bus transfer sequencer.
package bus_pkg;

    localparam int DATA_BUS_WIDTH = 8;
    localparam int CODE_W         = 4;
    localparam int DRIVE_W        = 8;
    localparam int LOAD_W         = 9;

    // Source and destination share one code space so src==dst means the same register.
    typedef enum logic [3:0] {
        SRC_A    = 4'd0,
        SRC_B    = 4'd1,
        SRC_C    = 4'd2,
        SRC_D    = 4'd3,
        SRC_M    = 4'd4,
        SRC_XY   = 4'd5,
        SRC_J    = 4'd6,
        SRC_INST = 4'd7,
        SRC_ALU  = 4'd8,
        SRC_MEM  = 4'd9
    } bus_src_t;

    typedef enum logic [3:0] {
        DST_A    = 4'd0,
        DST_B    = 4'd1,
        DST_C    = 4'd2,
        DST_D    = 4'd3,
        DST_M    = 4'd4,
        DST_XY   = 4'd5,
        DST_J    = 4'd6,
        DST_INST = 4'd7,
        DST_ALU  = 4'd8,
        DST_MEM  = 4'd9
    } bus_dst_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Code carried by each enable bit, bit 0 in the least significant nibble.
    localparam logic [DRIVE_W*CODE_W-1:0] SRC_MAP = {
        SRC_MEM, SRC_ALU, SRC_XY, SRC_M, SRC_D, SRC_C, SRC_B, SRC_A
    };
    localparam logic [LOAD_W*CODE_W-1:0] DST_MAP = {
        DST_MEM, DST_INST, DST_J, DST_XY, DST_M, DST_D, DST_C, DST_B, DST_A
    };

    function automatic logic [DRIVE_W-1:0] src_onehot(input logic [CODE_W-1:0] code);
        logic [DRIVE_W-1:0] oh;
        oh = '0;
        for (int i = 0; i < DRIVE_W; i++) begin
            oh[i] = (code == SRC_MAP[i*CODE_W +: CODE_W]);
        end
        return oh;
    endfunction

    function automatic logic [LOAD_W-1:0] dst_onehot(input logic [CODE_W-1:0] code);
        logic [LOAD_W-1:0] oh;
        oh = '0;
        for (int i = 0; i < LOAD_W; i++) begin
            oh[i] = (code == DST_MAP[i*CODE_W +: CODE_W]);
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_onehot_decoder.sv
// Maps a register code onto a one-hot enable vector through a per-bit code table.
module bus_onehot_decoder
    import bus_pkg::*;
#(
    parameter int                        OUT_W    = 8,
    parameter logic [OUT_W*CODE_W-1:0]   CODE_MAP = '0
) (
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [OUT_W-1:0]  onehot
);

    // Table entries are distinct, so at most one bit can match.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = en && (code == CODE_MAP[i*CODE_W +: CODE_W]);
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register-to-register bus transfer: drive source, strobe destination,
// hold drive one extra cycle, then report completion. All outputs are registered.
module bus_transfer_sequencer #(
    parameter int DATA_BUS_WIDTH = bus_pkg::DATA_BUS_WIDTH,
    parameter int SETTLE_CYCLES  = 2,
    parameter int LOAD_CYCLES    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req,
    input  logic [3:0]                src,
    input  logic [3:0]                dst,
    input  logic [DATA_BUS_WIDTH-1:0] data,
    output logic [7:0]                drive_en,
    output logic [8:0]                load_en,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [DATA_BUS_WIDTH-1:0] last_data
);
    import bus_pkg::*;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LOAD_RELOAD   = 4'(LOAD_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [CODE_W-1:0]         src_code_q, src_code_d;
    logic [CODE_W-1:0]         dst_code_q, dst_code_d;
    logic [DRIVE_W-1:0]        drive_en_q, drive_en_d;
    logic [LOAD_W-1:0]         load_en_q, load_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic [DATA_BUS_WIDTH-1:0] last_data_q, last_data_d;
    logic                      pair_legal_s;
    logic                      drive_on_s;
    logic                      load_on_s;

    // Codes that decode to nothing are J/INST as source, ALU as destination, or out of range.
    assign pair_legal_s = (src_onehot(src) != '0) && (dst_onehot(dst) != '0) && (src != dst);

    // Next-state, counter and pulse logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_code_d  = src_code_q;
        dst_code_d  = dst_code_q;
        error_d     = 1'b0;
        last_data_d = last_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req && pair_legal_s) begin
                    state_d    = ST_DRIVE;
                    cnt_d      = SETTLE_RELOAD;
                    src_code_d = src;
                    dst_code_d = dst;
                end else if (req) begin
                    error_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_LOAD;
                    cnt_d   = LOAD_RELOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_LOAD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_HOLD;
                    cnt_d       = 4'd0;
                    last_data_d = data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_DONE;
                cnt_d   = 4'd0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Enables are decoded from the next state so they register together with it.
    always_comb begin
        drive_on_s = (state_d == ST_DRIVE) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
        load_on_s  = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    bus_onehot_decoder #(
        .OUT_W    (DRIVE_W),
        .CODE_MAP (SRC_MAP)
    ) u_src_dec (
        .code   (src_code_d),
        .en     (drive_on_s),
        .onehot (drive_en_d)
    );

    bus_onehot_decoder #(
        .OUT_W    (LOAD_W),
        .CODE_MAP (DST_MAP)
    ) u_dst_dec (
        .code   (dst_code_d),
        .en     (load_on_s),
        .onehot (load_en_d)
    );

    // State and output registers; reset wins over everything and aborts any transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            src_code_q  <= 4'd0;
            dst_code_q  <= 4'd0;
            drive_en_q  <= '0;
            load_en_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_code_q  <= src_code_d;
            dst_code_q  <= dst_code_d;
            drive_en_q  <= drive_en_d;
            load_en_q   <= load_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            last_data_q <= last_data_d;
        end
    end

    assign drive_en  = drive_en_q;
    assign load_en   = load_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign last_data = last_data_q;

endmodule
